assoc_cache: RTL and testbench

//  Parametrised N-way set-associative write-back cache sitting between the core's load/store

---
 rtl/cache_pkg.sv | 31 +++
 rtl/cache_set_ram.sv | 63 ++++++
 rtl/assoc_cache.sv | 223 ++++++++++++++++++++++
 tb/tb_assoc_cache.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared types and width helpers for the set-associative write-back cache.
// Latency: none (declarations only); backpressure: n/a.
// Address split helpers assume power-of-two SETS/WORDS and 32-bit words.
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RESPOND   = 2'd1,
        WRITEBACK = 2'd2,
        REFILL    = 2'd3
    } cache_state_t;

    localparam int WORD_W     = 32;
    localparam int BYTE_OFF_W = 2;

    typedef logic [WORD_W-1:0] word_t;

    function automatic int idx_bits(input int sets);
        return $clog2(sets);
    endfunction

    // A direct-mapped build still needs a one-bit way/pointer field.
    function automatic int way_bits(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

    function automatic int tag_bits(input int addr_w, input int sets, input int words);
        return addr_w - $clog2(sets) - $clog2(words) - BYTE_OFF_W;
    endfunction

endpackage

// File: rtl/cache_set_ram.sv
// Per-way tag/valid/dirty/line storage with combinational read of one set.
// Latency: read combinational, write lands on the next rising edge.
// Backpressure: none; a single write port, caller serialises updates.
module cache_set_ram
    import cache_pkg::*;
#(
    parameter int SETS  = 4,
    parameter int WAYS  = 2,
    parameter int WORDS = 4,
    parameter int TAG_W = 26,
    parameter int WAY_W = 1,
    parameter int IDX_W = 2
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic [IDX_W-1:0]        rd_idx,
    output logic [WAYS-1:0]         rd_valid,
    output logic [WAYS-1:0]         rd_dirty,
    output logic [TAG_W-1:0]        rd_tag  [WAYS],
    output logic [WORD_W*WORDS-1:0] rd_line [WAYS],
    input  logic                    wr_en,
    input  logic [WAY_W-1:0]        wr_way,
    input  logic [IDX_W-1:0]        wr_idx,
    input  logic [TAG_W-1:0]        wr_tag,
    input  logic [WORD_W*WORDS-1:0] wr_line,
    input  logic                    wr_dirty
);

    logic [WAYS-1:0]         valid_q [SETS];
    logic [WAYS-1:0]         dirty_q [SETS];
    logic [TAG_W-1:0]        tag_q   [SETS][WAYS];
    logic [WORD_W*WORDS-1:0] data_q  [SETS][WAYS];

    always_comb begin
        rd_valid = valid_q[rd_idx];
        rd_dirty = dirty_q[rd_idx];
        for (int w = 0; w < WAYS; w++) begin
            rd_tag[w]  = tag_q[rd_idx][w];
            rd_line[w] = data_q[rd_idx][w];
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
            end
        end else if (wr_en) begin
            valid_q[wr_idx][wr_way] <= 1'b1;
            dirty_q[wr_idx][wr_way] <= wr_dirty;
        end
    end

    // Tag and data contents survive reset; the cleared valid bits hide them.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            tag_q[wr_idx][wr_way]  <= wr_tag;
            data_q[wr_idx][wr_way] <= wr_line;
        end
    end

endmodule

// File: rtl/assoc_cache.sv
// N-way set-associative write-back cache with refill/write-back FSM; CACHE_BYTE_ACCESS_EN adds cpu_byte.
// Latency: hit answers one cycle after the request is sampled; miss adds write-back and refill.
// Backpressure: core holds cpu_req until the cpu_ready pulse; mem_req held until mem_ack.
module assoc_cache
    import cache_pkg::*;
#(
    parameter int SETS   = 4,
    parameter int WAYS   = 2,
    parameter int WORDS  = 4,
    parameter int ADDR_W = 32
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    cpu_req,
    input  logic                    cpu_we,
    input  logic [ADDR_W-1:0]       cpu_addr,
    input  logic [WORD_W-1:0]       cpu_wdata,
`ifdef CACHE_BYTE_ACCESS_EN
    input  logic                    cpu_byte,
`endif
    output logic [WORD_W-1:0]       cpu_rdata,
    output logic                    cpu_ready,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [WORD_W*WORDS-1:0] mem_wblock,
    input  logic [WORD_W*WORDS-1:0] mem_rblock,
    input  logic                    mem_ack
);

    localparam int IDX_W  = idx_bits(SETS);
    localparam int WSEL_W = $clog2(WORDS);
    localparam int OFF_W  = WSEL_W + BYTE_OFF_W;
    localparam int TAG_W  = tag_bits(ADDR_W, SETS, WORDS);
    localparam int WAY_W  = way_bits(WAYS);
    localparam int LINE_W = WORD_W * WORDS;

    cache_state_t state;

    logic [IDX_W-1:0]  cur_idx, req_idx;
    logic [TAG_W-1:0]  cur_tag, req_tag;
    logic [WSEL_W-1:0] cur_wsel;
    logic [WAY_W-1:0]  hit_way, vic_way, vic_q;
    logic [WAY_W-1:0]  rr_ptr [SETS];
    logic              hit, vic_found;

    logic [WAYS-1:0]   rd_valid, rd_dirty;
    logic [TAG_W-1:0]  rd_tag  [WAYS];
    logic [LINE_W-1:0] rd_line [WAYS];
    logic [LINE_W-1:0] hit_line, merged_line;
    word_t             hit_word, rd_result, wr_word;

    logic              ram_we, ram_dirty;
    logic [WAY_W-1:0]  ram_way;
    logic [IDX_W-1:0]  ram_idx;
    logic [TAG_W-1:0]  ram_tag;
    logic [LINE_W-1:0] ram_line;

    assign cur_idx  = cpu_addr[OFF_W +: IDX_W];
    assign cur_tag  = cpu_addr[ADDR_W-1 -: TAG_W];
    assign cur_wsel = cpu_addr[BYTE_OFF_W +: WSEL_W];

    cache_set_ram #(
        .SETS  (SETS),
        .WAYS  (WAYS),
        .WORDS (WORDS),
        .TAG_W (TAG_W),
        .WAY_W (WAY_W),
        .IDX_W (IDX_W)
    ) u_ram (
        .clock    (clock),
        .reset_n  (reset_n),
        .rd_idx   (cur_idx),
        .rd_valid (rd_valid),
        .rd_dirty (rd_dirty),
        .rd_tag   (rd_tag),
        .rd_line  (rd_line),
        .wr_en    (ram_we),
        .wr_way   (ram_way),
        .wr_idx   (ram_idx),
        .wr_tag   (ram_tag),
        .wr_line  (ram_line),
        .wr_dirty (ram_dirty)
    );

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (rd_valid[w] && rd_tag[w] == cur_tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    // Fill holes first; only a full set falls back to the round-robin pointer.
    always_comb begin
        vic_found = 1'b0;
        vic_way   = rr_ptr[cur_idx];
        for (int w = 0; w < WAYS; w++) begin
            if (!vic_found && !rd_valid[w]) begin
                vic_found = 1'b1;
                vic_way   = WAY_W'(w);
            end
        end
    end

    assign hit_line = rd_line[hit_way];
    assign hit_word = hit_line[{cur_wsel, 5'b0} +: WORD_W];

`ifdef CACHE_BYTE_ACCESS_EN
    logic [1:0] lane;
    assign lane = cpu_addr[1:0];

    always_comb begin
        rd_result = hit_word;
        wr_word   = cpu_wdata;
        if (cpu_byte) begin
            rd_result                   = {24'b0, hit_word[{lane, 3'b0} +: 8]};
            wr_word                     = hit_word;
            wr_word[{lane, 3'b0} +: 8]  = cpu_wdata[7:0];
        end
    end
`else
    logic unused_lane;
    assign unused_lane = ^cpu_addr[1:0];
    assign rd_result   = hit_word;
    assign wr_word     = cpu_wdata;
`endif

    always_comb begin
        merged_line                              = hit_line;
        merged_line[{cur_wsel, 5'b0} +: WORD_W]  = wr_word;
    end

    always_comb begin
        ram_we    = 1'b0;
        ram_way   = hit_way;
        ram_idx   = cur_idx;
        ram_tag   = cur_tag;
        ram_line  = merged_line;
        ram_dirty = 1'b1;
        if (reset_n) begin
            if (state == IDLE && cpu_req && hit && cpu_we) begin
                ram_we = 1'b1;
            end else if (state == REFILL && mem_req && mem_ack) begin
                ram_we    = 1'b1;
                ram_way   = vic_q;
                ram_idx   = req_idx;
                ram_tag   = req_tag;
                ram_line  = mem_rblock;
                ram_dirty = 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state      <= IDLE;
            cpu_ready  <= 1'b0;
            cpu_rdata  <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wblock <= '0;
            req_idx    <= '0;
            req_tag    <= '0;
            vic_q      <= '0;
            for (int s = 0; s < SETS; s++) rr_ptr[s] <= '0;
        end else begin
            cpu_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (cpu_req) begin
                        if (hit) begin
                            state     <= RESPOND;
                            cpu_ready <= 1'b1;
                            cpu_rdata <= cpu_we ? '0 : rd_result;
                        end else begin
                            req_idx <= cur_idx;
                            req_tag <= cur_tag;
                            vic_q   <= vic_way;
                            mem_req <= 1'b1;
                            if (rd_valid[vic_way] && rd_dirty[vic_way]) begin
                                state      <= WRITEBACK;
                                mem_we     <= 1'b1;
                                mem_addr   <= {rd_tag[vic_way], cur_idx, {OFF_W{1'b0}}};
                                mem_wblock <= rd_line[vic_way];
                            end else begin
                                state    <= REFILL;
                                mem_we   <= 1'b0;
                                mem_addr <= {cur_tag, cur_idx, {OFF_W{1'b0}}};
                            end
                        end
                    end
                end
                RESPOND: state <= IDLE;
                WRITEBACK: begin
                    if (mem_ack) begin
                        state   <= REFILL;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                    end
                end
                REFILL: begin
                    // After a write-back, mem_req sits low one cycle before the refill starts.
                    if (!mem_req) begin
                        mem_req  <= 1'b1;
                        mem_addr <= {req_tag, req_idx, {OFF_W{1'b0}}};
                    end else if (mem_ack) begin
                        state           <= IDLE;
                        mem_req         <= 1'b0;
                        rr_ptr[req_idx] <= (rr_ptr[req_idx] == WAY_W'(WAYS - 1)) ? '0
                                           : rr_ptr[req_idx] + WAY_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_assoc_cache.sv
// Bench for assoc_cache: directed vector table, mid-refill reset sequence and random traffic
// checked against a flat-memory model with a latency-randomised memory responder.
module tb_assoc_cache;

    logic         clock = 1'b0;
    logic         reset_n;
    logic         cpu_req, cpu_we;
    logic [31:0]  cpu_addr, cpu_wdata, cpu_rdata;
    logic         cpu_ready;
`ifdef CACHE_BYTE_ACCESS_EN
    logic         cpu_byte;
`endif
    logic         mem_req, mem_we, mem_ack;
    logic [31:0]  mem_addr;
    logic [127:0] mem_wblock, mem_rblock;

    always #5 clock = ~clock;

    assoc_cache #(.SETS(4), .WAYS(2), .WORDS(4), .ADDR_W(32)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
`ifdef CACHE_BYTE_ACCESS_EN
        .cpu_byte   (cpu_byte),
`endif
        .cpu_rdata  (cpu_rdata),
        .cpu_ready  (cpu_ready),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wblock (mem_wblock),
        .mem_rblock (mem_rblock),
        .mem_ack    (mem_ack)
    );

    int          n_vec = 0;
    int          n_bad = 0;
    logic [31:0] bmem [128];
    logic [31:0] gold [128];
    int          n_wb = 0;
    int          n_rf = 0;
    logic [31:0] last_wb_addr = '0;
    logic [31:0] last_rf_addr = '0;
    bit          auto_mem = 1'b1;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endfunction

    // Backing memory: acks one request after a random 0..3 cycle delay.
    initial begin
        int wait_c;
        int lat_c;
        wait_c     = 0;
        lat_c      = 0;
        mem_ack    = 1'b0;
        mem_rblock = '0;
        forever begin
            @(negedge clock);
            if (mem_ack) begin
                mem_ack = 1'b0;
            end else if (mem_req && auto_mem) begin
                if (wait_c < lat_c) begin
                    wait_c++;
                end else begin
                    wait_c = 0;
                    lat_c  = $urandom_range(0, 3);
                    check("mem_addr_line_aligned", {28'h0, mem_addr[3:0]}, 32'h0);
                    if (mem_we) begin
                        n_wb++;
                        last_wb_addr = mem_addr;
                        for (int w = 0; w < 4; w++) bmem[{mem_addr[8:4], 2'(w)}] = mem_wblock[w*32 +: 32];
                    end else begin
                        n_rf++;
                        last_rf_addr = mem_addr;
                        for (int w = 0; w < 4; w++) mem_rblock[w*32 +: 32] = bmem[{mem_addr[8:4], 2'(w)}];
                    end
                    mem_ack = 1'b1;
                end
            end else begin
                wait_c = 0;
            end
        end
    end

    // Dirty lines die with reset, so the visible memory becomes the backing store.
    task automatic sync_gold();
        for (int i = 0; i < 128; i++) gold[i] = bmem[i];
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset_n = 1'b0;
        cpu_req = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        sync_gold();
    endtask

    task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                          input logic byt, output logic [31:0] rd, output int lat);
        @(negedge clock);
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wd;
`ifdef CACHE_BYTE_ACCESS_EN
        cpu_byte  = byt;
`endif
        lat = 0;
        rd  = '0;
        do begin
            @(posedge clock);
            #1;
            lat++;
        end while (!cpu_ready && lat < 300);
        if (cpu_ready) begin
            rd = cpu_rdata;
        end else begin
            n_vec++;
            n_bad++;
            $display("FAIL access_timeout: addr 0x%08h got no cpu_ready within %0d cycles", addr, lat);
            lat = -1;
        end
        cpu_req = 1'b0;
    endtask

    typedef struct {
        bit          rst;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        bit          exp_hit;
        bit          exp_wb;
        logic [31:0] exp_wb_addr;
        logic [31:0] exp_rf_addr;
    } vec_t;

    vec_t        tbl [13];
    logic [31:0] rd;
    int          lat, wb0, rf0, cyc;

    initial begin
        reset_n   = 1'b1;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
`ifdef CACHE_BYTE_ACCESS_EN
        cpu_byte  = 1'b0;
`endif
        for (int i = 0; i < 128; i++) bmem[i] = 32'h1000_0000 + i;
        bmem[16] = 32'h11; bmem[17] = 32'h22; bmem[18] = 32'h33; bmem[19] = 32'h44;

        //            rst we  addr     wdata          exp_rd         hit wb  wb_addr rf_addr
        tbl[0]  = '{0, 0, 32'h044, 32'h0,         32'h22,         0, 0, 32'h0, 32'h040};
        tbl[1]  = '{0, 1, 32'h044, 32'hDEADBEEF,  32'h0,          1, 0, 32'h0, 32'h0};
        tbl[2]  = '{0, 0, 32'h044, 32'h0,         32'hDEADBEEF,   1, 0, 32'h0, 32'h0};
        tbl[3]  = '{1, 0, 32'h000, 32'h0,         32'h1000_0000,  0, 0, 32'h0, 32'h000};
        tbl[4]  = '{0, 1, 32'h000, 32'h0BADF00D,  32'h0,          1, 0, 32'h0, 32'h0};
        tbl[5]  = '{0, 0, 32'h100, 32'h0,         32'h1000_0040,  0, 0, 32'h0, 32'h100};
        tbl[6]  = '{0, 0, 32'h080, 32'h0,         32'h1000_0020,  0, 1, 32'h0, 32'h080};
        tbl[7]  = '{0, 0, 32'h100, 32'h0,         32'h1000_0040,  1, 0, 32'h0, 32'h0};
        tbl[8]  = '{0, 0, 32'h0C0, 32'h0,         32'h1000_0030,  0, 0, 32'h0, 32'h0C0};
        tbl[9]  = '{0, 0, 32'h000, 32'h0,         32'h0BADF00D,   0, 0, 32'h0, 32'h000};
        tbl[10] = '{0, 0, 32'h044, 32'h0,         32'h22,         0, 0, 32'h0, 32'h040};
        tbl[11] = '{0, 1, 32'h010, 32'h12345678,  32'h0,          0, 0, 32'h0, 32'h010};
        tbl[12] = '{0, 0, 32'h010, 32'h0,         32'h12345678,   1, 0, 32'h0, 32'h0};

        do_reset();
        check("reset_cpu_ready", {31'b0, cpu_ready}, 32'h0);
        check("reset_cpu_rdata", cpu_rdata, 32'h0);
        check("reset_mem_req",   {31'b0, mem_req}, 32'h0);
        check("reset_mem_we",    {31'b0, mem_we}, 32'h0);
        check("reset_mem_addr",  mem_addr, 32'h0);

        for (int i = 0; i < 13; i++) begin
            if (tbl[i].rst) do_reset();
            wb0 = n_wb;
            rf0 = n_rf;
            access(tbl[i].we, tbl[i].addr, tbl[i].wdata, 1'b0, rd, lat);
            check($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rd);
            check($sformatf("vec%0d_hit", i), {31'b0, (lat == 1 && n_rf == rf0)}, {31'b0, tbl[i].exp_hit});
            check($sformatf("vec%0d_writebacks", i), n_wb - wb0, {31'b0, tbl[i].exp_wb});
            if (!tbl[i].exp_hit) check($sformatf("vec%0d_refill_addr", i), last_rf_addr, tbl[i].exp_rf_addr);
            if (tbl[i].exp_wb) check($sformatf("vec%0d_wb_addr", i), last_wb_addr, tbl[i].exp_wb_addr);
            @(posedge clock);
            #1;
            check($sformatf("vec%0d_ready_one_cycle", i), {31'b0, cpu_ready}, 32'h0);
        end

        // Reset lands while a refill is outstanding and unacknowledged.
        do_reset();
        auto_mem = 1'b0;
        @(negedge clock);
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 32'h084;
        cyc = 0;
        do begin
            @(posedge clock);
            #1;
            cyc++;
        end while (!(mem_req && !mem_we) && cyc < 50);
        check("midrst_refill_req", {31'b0, mem_req}, 32'h1);
        check("midrst_refill_addr", mem_addr, 32'h080);
        @(negedge clock);
        reset_n = 1'b0;
        @(posedge clock);
        #1;
        check("midrst_mem_req", {31'b0, mem_req}, 32'h0);
        check("midrst_cpu_ready", {31'b0, cpu_ready}, 32'h0);
        @(negedge clock);
        reset_n  = 1'b1;
        cpu_req  = 1'b0;
        auto_mem = 1'b1;
        sync_gold();
        rf0 = n_rf;
        access(1'b0, 32'h084, 32'h0, 1'b0, rd, lat);
        check("midrst_reread_data", rd, 32'h1000_0021);
        check("midrst_reread_miss", n_rf - rf0, 32'h1);

`ifdef CACHE_BYTE_ACCESS_EN
        access(1'b1, 32'h044, 32'hDEADBEEF, 1'b0, rd, lat);
        access(1'b1, 32'h045, 32'h000000AB, 1'b1, rd, lat);
        access(1'b0, 32'h044, 32'h0, 1'b0, rd, lat);
        check("byte_write_merge", rd, 32'hDEADABEF);
        access(1'b0, 32'h045, 32'h0, 1'b1, rd, lat);
        check("byte_read_lane1", rd, 32'h000000AB);
        access(1'b0, 32'h047, 32'h0, 1'b1, rd, lat);
        check("byte_read_lane3", rd, 32'h000000DE);
`endif

        // Random traffic against a flat word-addressed memory model.
        do_reset();
        for (int n = 0; n < 600; n++) begin
            int          widx;
            int          lane;
            logic        we;
            logic        byt;
            logic [31:0] wd;
            logic [31:0] exp;
            widx = $urandom_range(0, 127);
            we   = 1'($urandom_range(0, 1));
            wd   = $urandom;
            byt  = 1'b0;
            lane = 0;
`ifdef CACHE_BYTE_ACCESS_EN
            byt  = ($urandom_range(0, 3) == 0);
            lane = byt ? $urandom_range(0, 3) : 0;
`endif
            access(we, 32'(widx * 4 + lane), wd, byt, rd, lat);
            exp = 32'h0;
            if (we) begin
                if (byt) gold[widx] = (gold[widx] & ~(32'hFF << (8 * lane))) | ((wd & 32'hFF) << (8 * lane));
                else     gold[widx] = wd;
            end else begin
                if (byt) exp = (gold[widx] >> (8 * lane)) & 32'hFF;
                else     exp = gold[widx];
            end
            check($sformatf("rand%0d_rdata@0x%03h", n, widx * 4 + lane), rd, exp);
        end

        for (int i = 0; i < 128; i++) begin
            access(1'b0, 32'(i * 4), 32'h0, 1'b0, rd, lat);
            check($sformatf("sweep_rdata@0x%03h", i * 4), rd, gold[i]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
